status_light_ctrl: RTL and testbench

Parametrised successor to the bottle-filler status-light encoder. It registers the machine's mode inputs (work enable, set enable, SET, allFull) and drives a WIDTH-bit status-light bus. Beyond the 4-bit mode code, it adds a latched full-bottle alarm with acknowledge/re-arm and a counter-driven blink. It sits between the mode/control logic and the panel light drivers.

---
 rtl/status_light_ctrl_if.sv | 25 ++
 rtl/status_light_ctrl.sv | 156 +++++++++++++++
 tb/tb_status_light_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/status_light_ctrl_if.sv
// Status-light controller bus: machine mode inputs toward the controller,
// and the registered light code and alarm flag back to the panel side.
interface status_light_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             EN_work;
  logic             EN_set;
  logic             SET;
  logic             allFull;
  logic             ACK;
  logic [WIDTH-1:0] light;
  logic             alarm;

  // Mode/control logic side: drives the mode inputs, observes the lights
  modport master (
    output EN_work, EN_set, SET, allFull, ACK,
    input  light, alarm
  );

  // Controller side
  modport slave (
    input  EN_work, EN_set, SET, allFull, ACK,
    output light, alarm
  );
endinterface

// File: rtl/status_light_ctrl.sv
// status_light_ctrl: two-stage status-light encoder for the bottle filler.
// Stage 1 registers the mode inputs; stage 2 runs the mode FSM, the latched
// full-bottle alarm (acknowledge / re-arm) and drives the registered light
// code and alarm flag.
// Build option: define LIGHT_BLINK_EN to make the ALARM light blink with a
// BLINK_DIV-cycle half-period; without it ALARM shows a steady 0110.
module status_light_ctrl #(
  parameter int WIDTH     = 4,
  parameter int BLINK_DIV = 4
) (
  input  logic                CLK,
  input  logic                RST,
  status_light_ctrl_if.slave  bus
);

  // Reject unusable configurations at elaboration time.
  if (WIDTH < 4 || BLINK_DIV < 2) begin : g_param_check
    $error("status_light_ctrl: WIDTH must be >= 4 and BLINK_DIV >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WORK  = 3'd2,
    ST_FAULT = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  logic s_work_q, s_set_q, s_sel_q, s_full_q, s_ack_q;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] light_q, light_d;
  logic             alarm_q, alarm_d;
  logic             on_phase;

  // Stage 1: sample the raw mode inputs every edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_work_q <= 1'b0;
      s_set_q  <= 1'b0;
      s_sel_q  <= 1'b0;
      s_full_q <= 1'b0;
      s_ack_q  <= 1'b0;
    end else begin
      s_work_q <= bus.EN_work;
      s_set_q  <= bus.EN_set;
      s_sel_q  <= bus.SET;
      s_full_q <= bus.allFull;
      s_ack_q  <= bus.ACK;
    end
  end

  // Stage 2 next state: mode decode with FAULT on top, alarm latch inside WORK
  always_comb begin
    state_d = state_q;
    if (s_work_q && s_set_q) begin
      state_d = ST_FAULT;
    end else if (!s_work_q && s_set_q) begin
      state_d = ST_SETUP;
    end else if (!s_work_q && !s_set_q) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_ALARM) begin
      state_d = s_ack_q ? ST_WORK : ST_ALARM;
    end else if (state_q == ST_WORK && s_full_q && armed_q && !s_ack_q) begin
      state_d = ST_ALARM;
    end else begin
      state_d = ST_WORK;
    end
  end

  // Re-arm whenever the bottles are not full; an acknowledged exit disarms so
  // a still-full line cannot retrigger the alarm immediately.
  always_comb begin
    armed_d = armed_q;
    if (!s_full_q) begin
      armed_d = 1'b1;
    end else if (state_q == ST_ALARM && state_d == ST_WORK) begin
      armed_d = 1'b0;
    end
  end

`ifdef LIGHT_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Blink timing: count only while staying in ALARM; entry restarts on-phase
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b1;
    if (state_q == ST_ALARM && state_d == ST_ALARM) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign on_phase = phase_d;
`else
  assign on_phase = 1'b1;
`endif

  // Output decode from the state being entered so light tracks state exactly
  always_comb begin
    light_d = '0;
    alarm_d = 1'b0;
    case (state_d)
      ST_IDLE:  light_d[3:0] = s_sel_q ? 4'b0010 : 4'b0001;
      ST_SETUP: light_d[3:0] = 4'b0011;
      ST_WORK:  light_d[3:0] = s_sel_q ? 4'b0101 : 4'b0100;
      ST_FAULT: light_d[3:0] = 4'b0000;
      ST_ALARM: begin
        light_d[3:0] = on_phase ? 4'b0110 : 4'b0000;
        alarm_d      = 1'b1;
      end
      default:  light_d = '0;
    endcase
  end

  // Stage 2 registers: FSM state, armed flag and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b1;
      light_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      light_q <= light_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.light = light_q;
  assign bus.alarm = alarm_q;

endmodule

// File: tb/tb_status_light_ctrl.sv
// Directed scoreboard bench for status_light_ctrl (WIDTH=4, BLINK_DIV=4).
// Each step drives inputs for one cycle and queues the light/alarm expected
// right after the following edge; a monitor pops and compares every cycle.
module tb_status_light_ctrl;
  localparam int WIDTH     = 4;
  localparam int BLINK_DIV = 4;
  // Table marker for the ALARM off-phase slot
  localparam logic [3:0] OFF = 4'hF;
`ifdef LIGHT_BLINK_EN
  localparam logic [3:0] OFF_CODE = 4'b0000;
`else
  localparam logic [3:0] OFF_CODE = 4'b0110;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  status_light_ctrl_if #(.WIDTH(WIDTH)) bus ();

  status_light_ctrl #(.WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    int               idx;
    logic [WIDTH-1:0] light;
    logic             alarm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic step(input logic r, input logic w, input logic s, input logic t,
                      input logic f, input logic a, input logic [3:0] l, input logic al);
    exp_t e;
    @(negedge CLK);
    RST         = r;
    bus.EN_work = w;
    bus.EN_set  = s;
    bus.SET     = t;
    bus.allFull = f;
    bus.ACK     = a;
    step_no++;
    e.idx   = step_no;
    e.light = WIDTH'((l == OFF) ? OFF_CODE : l);
    e.alarm = al;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.light !== e.light || bus.alarm !== e.alarm) begin
        n_fail++;
        $display("FAIL step%0d: light=%b alarm=%b, expected light=%b alarm=%b",
                 e.idx, bus.light, bus.alarm, e.light, e.alarm);
      end
    end
  end

  initial begin
    RST = 1'b1;
    bus.EN_work = 1'b0; bus.EN_set = 1'b0; bus.SET = 1'b0;
    bus.allFull = 1'b0; bus.ACK = 1'b0;

    // Reset and mode walk        r  w  s  t  f  a  light    alarm
    step(1, 0, 0, 0, 0, 0, 4'b0000, 0);
    step(1, 0, 0, 0, 0, 0, 4'b0000, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 4'b0001, 0);
    step(0, 0, 0, 1, 0, 0, 4'b0001, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0, 4'b0010, 0);
    step(0, 0, 1, 0, 0, 0, 4'b0010, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0, 4'b0011, 0);
    step(0, 1, 0, 0, 0, 0, 4'b0011, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0, 4'b0100, 0);
    step(0, 1, 0, 1, 0, 0, 4'b0100, 0);
    repeat (2) step(0, 1, 0, 1, 0, 0, 4'b0101, 0);
    step(0, 1, 1, 0, 0, 0, 4'b0101, 0);
    repeat (2) step(0, 1, 1, 0, 0, 0, 4'b0000, 0);

    // Alarm blink: 4 on, 4 off, 4 on
    step(0, 1, 0, 0, 0, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    repeat (4) step(0, 1, 0, 0, 1, 0, 4'b0110, 1);
    repeat (4) step(0, 1, 0, 0, 1, 0, OFF,     1);
    repeat (4) step(0, 1, 0, 0, 1, 0, 4'b0110, 1);

    // ACK pulse, no re-entry while full, re-arm on allFull drop
    step(0, 1, 0, 0, 1, 1, OFF,     1);
    repeat (3) step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    step(0, 1, 0, 0, 0, 0, 4'b0100, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    repeat (2) step(0, 1, 0, 0, 1, 0, 4'b0110, 1);

    // Fault overrides ALARM; alarm re-entered on-phase first
    step(0, 1, 1, 0, 1, 0, 4'b0110, 1);
    step(0, 1, 1, 0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    repeat (4) step(0, 1, 0, 0, 1, 0, 4'b0110, 1);
    repeat (2) step(0, 1, 0, 0, 1, 0, OFF,     1);

    // Reset during off-phase, release with inputs held
    step(1, 1, 0, 0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0001, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    repeat (4) step(0, 1, 0, 0, 1, 0, 4'b0110, 1);
    step(0, 1, 0, 0, 1, 0, OFF,     1);

    // ACK with allFull in WORK blocks entry only for that cycle
    step(0, 1, 0, 0, 1, 1, OFF,     1);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    step(0, 1, 0, 0, 0, 0, 4'b0100, 0);
    step(0, 1, 0, 0, 1, 1, 4'b0100, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    repeat (2) step(0, 1, 0, 0, 1, 0, 4'b0110, 1);

    // Fault together with ACK in ALARM: fault wins, armed kept
    step(0, 1, 1, 0, 1, 1, 4'b0110, 1);
    step(0, 1, 0, 0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0100, 0);
    step(0, 1, 0, 0, 1, 0, 4'b0110, 1);
    step(0, 0, 0, 0, 0, 0, 4'b0110, 1);
    step(0, 0, 0, 0, 0, 0, 4'b0001, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
